// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative, write-back, write-allocate data cache.
// Define CACHE_STATS_EN to add saturating stat_hits/stat_misses counters.
module assoc_wb_cache #(
  parameter int WAYS        = 2,
  parameter int SETS        = 256,
  parameter int LINE_BYTES  = 64,
  parameter int ADDRESSSIZE = 64,
  parameter int WIDTH       = 64,
  localparam int OFFWIDTH   = $clog2(LINE_BYTES),
  localparam int IDXWIDTH   = $clog2(SETS),
  localparam int TAGWIDTH   = ADDRESSSIZE - IDXWIDTH - OFFWIDTH,
  localparam int BLOCKSZ    = LINE_BYTES * 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [ADDRESSSIZE-1:0] addr,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [1:0]             mem_datasize,
  output logic [WIDTH-1:0]       data_out,
  output logic                   operation_complete,
  output logic                   access_err,
  output logic                   busy,
  output logic                   mem_req,
  output logic                   mem_wr_en,
  output logic [ADDRESSSIZE-1:0] mem_address,
  output logic [BLOCKSZ-1:0]     mem_data_out,
  input  logic [BLOCKSZ-1:0]     mem_data_in,
  input  logic                   mem_data_valid,
  input  logic                   cache_invalid_bit,
  input  logic [ADDRESSSIZE-1:0] cache_invalid_bit_addr
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_misses
`endif
);

  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND
  } state_t;

  typedef logic [TAGWIDTH-1:0] tag_t;
  typedef logic [IDXWIDTH-1:0] idx_t;
  typedef logic [WAYW-1:0]     way_t;
  typedef logic [BLOCKSZ-1:0]  line_t;

  state_t                    state_q;
  logic [ADDRESSSIZE-1:0]    addr_q;
  logic                      wr_q;
  logic [WIDTH-1:0]          din_q;
  logic [1:0]                size_q;
  way_t                      way_q;
  logic                      inv_q;

  line_t                     data_q [WAYS][SETS];
  tag_t                      tag_q  [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [WAYS-1:0][SETS-1:0] dirty_q;
  way_t [SETS-1:0]           vptr_q;

  logic [WIDTH-1:0]          data_out_q;
  logic                      done_q;
  logic                      err_q;
  logic                      mem_req_q;
  logic                      mem_wr_q;
  logic [ADDRESSSIZE-1:0]    mem_addr_q;
  line_t                     mem_dout_q;

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    unique case (s)
      2'd0: size_mask = 64'h0000_0000_0000_00FF;
      2'd1: size_mask = 64'h0000_0000_0000_FFFF;
      2'd2: size_mask = 64'h0000_0000_FFFF_FFFF;
      2'd3: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] s);
    unique case (s)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      2'd3: align_mask = 3'b111;
    endcase
  endfunction

  function automatic way_t ptr_inc(input way_t p);
    return (WAYS == 1) ? '0 : way_t'(p + 1'b1);
  endfunction

  idx_t                 set_a;
  idx_t                 set_i;
  tag_t                 tag_a;
  tag_t                 tag_i;
  logic [OFFWIDTH-1:0]  off_a;
  logic                 mis_in;

  assign set_a  = addr_q[OFFWIDTH +: IDXWIDTH];
  assign tag_a  = addr_q[ADDRESSSIZE-1 -: TAGWIDTH];
  assign off_a  = addr_q[OFFWIDTH-1:0];
  assign set_i  = cache_invalid_bit_addr[OFFWIDTH +: IDXWIDTH];
  assign tag_i  = cache_invalid_bit_addr[ADDRESSSIZE-1 -: TAGWIDTH];
  assign mis_in = |(addr[2:0] & align_mask(mem_datasize));

  logic hit;
  logic ihit;
  logic vic_found;
  way_t hit_way;
  way_t inv_way;
  way_t victim;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    ihit      = 1'b0;
    inv_way   = '0;
    vic_found = 1'b0;
    victim    = vptr_q[set_a];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][set_a] && tag_q[w][set_a] == tag_a) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
      if (valid_q[w][set_i] && tag_q[w][set_i] == tag_i) begin
        ihit    = 1'b1;
        inv_way = way_t'(w);
      end
      if (!vic_found && !valid_q[w][set_a]) begin
        vic_found = 1'b1;
        victim    = way_t'(w);
      end
    end
  end

  // Byte-lane view of the hit line at the request offset
  logic [63:0]      smask;
  line_t            line_h;
  line_t            bmask;
  line_t            wsh;
  line_t            line_d;
  logic [WIDTH-1:0] rdata_d;

  assign smask   = size_mask(size_q);
  assign line_h  = data_q[hit_way][set_a];
  assign bmask   = line_t'(smask) << {off_a, 3'b000};
  assign wsh     = line_t'(din_q) << {off_a, 3'b000};
  assign line_d  = (line_h & ~bmask) | (wsh & bmask);
  assign rdata_d = WIDTH'(line_h >> {off_a, 3'b000}) & WIDTH'(smask);

  logic  arr_we;
  way_t  arr_way;
  line_t arr_line;

  always_comb begin
    arr_we   = 1'b0;
    arr_way  = hit_way;
    arr_line = line_d;
    if (state_q == LOOKUP && hit && wr_q) begin
      arr_we = 1'b1;
    end else if (state_q == REFILL && mem_req_q && mem_data_valid) begin
      arr_we   = 1'b1;
      arr_way  = way_q;
      arr_line = mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_q[arr_way][set_a] <= arr_line;
      tag_q[arr_way][set_a]  <= tag_a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      din_q      <= '0;
      size_q     <= '0;
      way_q      <= '0;
      inv_q      <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
      vptr_q     <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cache_invalid_bit) begin
            if (ihit && dirty_q[inv_way][set_i]) begin
              state_q    <= WRITEBACK;
              inv_q      <= 1'b1;
              way_q      <= inv_way;
              addr_q     <= cache_invalid_bit_addr;
              mem_req_q  <= 1'b1;
              mem_wr_q   <= 1'b1;
              mem_addr_q <= {tag_q[inv_way][set_i], set_i,
                             {OFFWIDTH{1'b0}}};
              mem_dout_q <= data_q[inv_way][set_i];
            end else if (ihit) begin
              valid_q[inv_way][set_i] <= 1'b0;
            end
          end else if (enable) begin
            addr_q <= addr;
            wr_q   <= wr_en;
            din_q  <= data_in;
            size_q <= mem_datasize;
            if (mis_in) begin
              state_q    <= RESPOND;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              data_out_q <= '0;
            end else begin
              state_q <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          if (hit) begin
            state_q <= RESPOND;
            done_q  <= 1'b1;
            if (wr_q) begin
              dirty_q[hit_way][set_a] <= 1'b1;
              vptr_q[set_a]           <= ptr_inc(hit_way);
              data_out_q              <= '0;
            end else begin
              data_out_q <= rdata_d;
            end
          end else begin
            way_q     <= victim;
            mem_req_q <= 1'b1;
            if (valid_q[victim][set_a] && dirty_q[victim][set_a]) begin
              state_q    <= WRITEBACK;
              mem_wr_q   <= 1'b1;
              mem_addr_q <= {tag_q[victim][set_a], set_a,
                             {OFFWIDTH{1'b0}}};
              mem_dout_q <= data_q[victim][set_a];
            end else begin
              state_q    <= REFILL;
              mem_wr_q   <= 1'b0;
              mem_addr_q <= {addr_q[ADDRESSSIZE-1:OFFWIDTH],
                             {OFFWIDTH{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_data_valid) begin
            mem_req_q              <= 1'b0;
            dirty_q[way_q][set_a]  <= 1'b0;
            if (inv_q) begin
              inv_q                 <= 1'b0;
              valid_q[way_q][set_a] <= 1'b0;
              state_q               <= IDLE;
            end else begin
              state_q <= REFILL;
            end
          end
        end
        REFILL: begin
          // After a writeback the request drops for a cycle, then reissues
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {addr_q[ADDRESSSIZE-1:OFFWIDTH],
                           {OFFWIDTH{1'b0}}};
          end else if (mem_data_valid) begin
            mem_req_q             <= 1'b0;
            valid_q[way_q][set_a] <= 1'b1;
            dirty_q[way_q][set_a] <= 1'b0;
            vptr_q[set_a]         <= ptr_inc(vptr_q[set_a]);
            state_q               <= LOOKUP;
          end
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out           = data_out_q;
  assign operation_complete = done_q;
  assign access_err         = err_q;
  assign busy               = (state_q != IDLE);
  assign mem_req            = mem_req_q;
  assign mem_wr_en          = mem_wr_q;
  assign mem_address        = mem_addr_q;
  assign mem_data_out       = mem_dout_q;

`ifdef CACHE_STATS_EN
  logic        first_q;
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q  <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        first_q <= 1'b1;
      end else if (state_q == LOOKUP && !hit) begin
        first_q <= 1'b0;
      end
      if (state_q == LOOKUP && hit && first_q && hits_q != '1) begin
        hits_q <= hits_q + 32'd1;
      end
      if (state_q == LOOKUP && !hit && misses_q != '1) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- N-way set-associative, write-back, write-allocate data cache.
- Parametrised successor of the team's direct-mapped, write-through cache.
- Sits between a pipeline memory stage (requester) and the memory arbiter: one request in flight, whole-line refills and evictions to the arbiter, invalidations from the memory controller via the arbiter.
- Adds to the direct-mapped design: configurable ways, sets and line size; dirty tracking; per-set round-robin victim choice; misalignment error reporting.

Parameters:
- WAYS, 2, associativity (power of 2, 1..8).
- SETS, 256, sets per way (power of 2).
- LINE_BYTES, 64, line size in bytes (power of 2, >=8).
- ADDRESSSIZE, 64, address width.
- WIDTH, 64, requester data width.
- Derived, not overridable: OFFWIDTH=log2(LINE_BYTES); IDXWIDTH=log2(SETS); TAGWIDTH=ADDRESSSIZE-IDXWIDTH-OFFWIDTH; BLOCKSZ=LINE_BYTES*8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  request valid; sampled only in IDLE.
- wr_en  in  1  1=store, 0=load.
- addr  in  ADDRESSSIZE  byte address.
- data_in  in  WIDTH  store data, right-aligned.
- mem_datasize  in  2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
- data_out  out  WIDTH  load data, zero-extended; valid while operation_complete=1.
- operation_complete  out  1  one-cycle done pulse.
- access_err  out  1  pulses together with operation_complete on a misaligned access.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  level; held until mem_data_valid.
- mem_wr_en  out  1  1=writeback, 0=refill; stable while mem_req=1.
- mem_address  out  ADDRESSSIZE  line-aligned (low OFFWIDTH bits 0).
- mem_data_out  out  BLOCKSZ  writeback line.
- mem_data_in  in  BLOCKSZ  refill line.
- mem_data_valid  in  1  one-cycle completion of the current mem_req.
- cache_invalid_bit  in  1  invalidation request pulse.
- cache_invalid_bit_addr  in  ADDRESSSIZE  invalidation address.

Behaviour:
- Reset (rst=0, asynchronous):
  - All valid, dirty and victim pointers cleared; state=IDLE.
  - All outputs 0. Data/tag arrays are not reset.
  - Reset mid-miss abandons the transaction; mem_req drops immediately.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - On enable=1, latch addr, wr_en, data_in, size; go to LOOKUP.
  - Misalignment check: addr mod size != 0. A misaligned request goes to RESPOND with access_err=1 and no array change.
  - Invalidation: cache_invalid_bit is honoured only in IDLE and has priority over enable (enable is then held off one cycle).
    - Matching valid clean way: valid cleared in one cycle.
    - Matching valid dirty way: WRITEBACK first, then valid cleared, then back to IDLE.
- LOOKUP:
  - Compare the tag against all WAYS ways of set addr[IDX] in parallel.
  - At most one way may match.
  - Hit load: data_out = line[off*8 +: size], zero-extended; go to RESPOND.
  - Hit store: byte-merge into the line, set dirty, update the victim pointer; go to RESPOND.
  - Miss: victim = first invalid way (lowest index), else way[victim_ptr[set]]. Victim dirty -> WRITEBACK; otherwise -> REFILL.
- WRITEBACK:
  - mem_req=1, mem_wr_en=1, mem_address={victim tag, set, 0}, mem_data_out=victim line.
  - On mem_data_valid, clear dirty and go to REFILL (or IDLE when the writeback is for an invalidation).
- REFILL:
  - mem_req=1, mem_wr_en=0, mem_address = addr with the offset cleared.
  - On mem_data_valid, write the line, tag and valid=1 (dirty=0) into the victim way; victim_ptr[set] increments mod WAYS; go to LOOKUP, which then hits.
- RESPOND: operation_complete=1 for exactly one cycle, then IDLE.
- Latency:
  - Hit: enable sampled at edge N, operation_complete high in cycle N+2.
  - Clean miss: 2 + memory latency + 2 cycles.
  - Dirty miss adds one writeback round trip.
- mem_req deasserts in the cycle after mem_data_valid.
- mem_data_valid outside WRITEBACK/REFILL is ignored.
- Store to a line under invalidation cannot occur (IDLE serialisation).
- enable high while busy is ignored; the requester holds enable until operation_complete.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs stat_hits and stat_misses (32 bits each, saturating).
  - hits counts LOOKUP hits on first lookup only.
  - misses counts transitions out of LOOKUP to WRITEBACK or REFILL.
  - Both cleared by reset.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Cold load 8B at 0x1000 -> REFILL with mem_address=0x1000; mem returns line with bytes 0..7 = 0x1122334455667788 -> data_out=0x1122334455667788, one complete pulse.
- Repeat load at 0x1000 -> no mem_req; operation_complete exactly 2 cycles after enable sampled.
- Store 1B 0xAB at 0x1003, then fill both ways of set 0x40 (0x1000 + k·0x4000), then a third conflicting load -> WRITEBACK of the dirty line with mem_address=0x1000 and byte 3 = 0xAB, then REFILL.
- Load 4B at 0x1002 -> access_err=1 with operation_complete, no mem_req, arrays unchanged.
- cache_invalid_bit with addr 0x1000 on a clean resident line -> next load at 0x1000 misses; on a dirty line -> writeback precedes the invalidation.
- Assert rst=0 mid-REFILL -> mem_req and busy low asynchronously; the next load misses.
